add_mul_frame_accumulator: RTL and testbench

// - Downstream consumer of the 4-bit combined add/mul datapath: registers its 8-bit product and 4-bit sum.
// - Accumulates FRAME_LEN products into a saturating sum and XOR-folds the sums into a 4-bit check word.
// - Presents one frame result per FRAME_LEN accepted samples on a valid/ready output interface.

---
 rtl/add_mul_pkg.sv | 22 ++
 rtl/add_mul_sat_adder.sv | 29 ++
 rtl/add_mul_frame_accumulator.sv | 135 +++++++++++++
 tb/tb_add_mul_frame_accumulator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/add_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_mul_pkg
//  Description : Shared widths and state encoding for the add/mul frame
//                accumulator and its saturating adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_mul_pkg;

  // Width of the upstream product and sum buses.
  localparam int MUL_W = 8;
  localparam int ADD_W = 4;

  // Frame FSM encoding, explicit 2-bit width.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/add_mul_sat_adder.sv
`default_nettype none
// ============================================================================
//  Module      : add_mul_sat_adder
//  Description : Combinational saturating add of an accumulator and a
//                zero-extended product. Clamps to all-ones on overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_mul_sat_adder
  import add_mul_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [MUL_W-1:0] mul_in,
  output logic [ACC_W-1:0] sum_out,
  output logic             sat_out
);

  logic [ACC_W:0] sum_wide;

  // One extra bit catches the carry; a set carry means the true sum overflowed.
  always_comb begin
    sum_wide = {1'b0, acc_in} + {{(ACC_W + 1 - MUL_W){1'b0}}, mul_in};
    sat_out  = sum_wide[ACC_W];
    sum_out  = sat_out ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/add_mul_frame_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : add_mul_frame_accumulator
//  Description : Accumulates FRAME_LEN products into a saturating sum and
//                XOR-folds the sums into a check word; one result per frame
//                is offered on a valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_mul_frame_accumulator
  import add_mul_pkg::*;
#(
  parameter int ACC_W     = 16,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MUL_W-1:0] mul_in,
  input  logic [ADD_W-1:0] add_in,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] mac_sum,
  output logic [ADD_W-1:0] add_chk,
  output logic             sat_flag,
  output logic [CNT_W-1:0] smp_cnt
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ADD_W-1:0]   chk_q, chk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic               accept;
  logic               start_frame;
  logic [ACC_W-1:0]   add_operand;
  logic [ACC_W-1:0]   add_sum;
  logic               add_sat;

  // Ready is withheld in reset, during clear, and while a result waits unread.
  always_comb begin
    in_ready    = ~rst & ~clear & ((state_q != HOLD) | out_ready);
    accept      = in_valid & in_ready;
    start_frame = accept & (state_q != ACCUM);
    add_operand = start_frame ? {ACC_W{1'b0}} : acc_q;
  end

  add_mul_sat_adder #(
    .ACC_W (ACC_W)
  ) u_sat_adder (
    .acc_in  (add_operand),
    .mul_in  (mul_in),
    .sum_out (add_sum),
    .sat_out (add_sat)
  );

  // Next-state logic: frame start, accumulation, hold/unload and abort.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    chk_d   = chk_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      chk_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (start_frame) begin
      // Covers both a fresh frame from IDLE and an unload-plus-restart in HOLD.
      acc_d   = add_sum;
      sat_d   = 1'b0;
      chk_d   = add_in;
      cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
      state_d = (FRAME_LEN == 1) ? HOLD : ACCUM;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d = add_sum;
            sat_d = sat_q | add_sat;
            chk_d = chk_q ^ add_in;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == FRAME_CNT) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      chk_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      chk_q   <= chk_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    out_valid = (state_q == HOLD);
    mac_sum   = acc_q;
    add_chk   = chk_q;
    sat_flag  = sat_q;
    smp_cnt   = cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_add_mul_frame_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_mul_frame_accumulator
//  Description : Directed self-checking bench for add_mul_frame_accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_mul_frame_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  mul_in = '0;
  logic [3:0]  add_in = '0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, sat_flag;
  logic [15:0] mac_sum;
  logic [3:0]  add_chk, smp_cnt;

  logic        in_ready9, out_valid9, sat_flag9;
  logic [8:0]  mac_sum9;
  logic [3:0]  add_chk9, smp_cnt9;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  add_mul_frame_accumulator #(.ACC_W(16), .FRAME_LEN(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mul_in(mul_in), .add_in(add_in), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .mac_sum(mac_sum),
    .add_chk(add_chk), .sat_flag(sat_flag), .smp_cnt(smp_cnt)
  );

  add_mul_frame_accumulator #(.ACC_W(9), .FRAME_LEN(4), .CNT_W(4)) dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9),
    .mul_in(mul_in), .add_in(add_in), .clear(clear),
    .out_valid(out_valid9), .out_ready(out_ready), .mac_sum(mac_sum9),
    .add_chk(add_chk9), .sat_flag(sat_flag9), .smp_cnt(smp_cnt9)
  );

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] m, input logic [3:0] a);
    in_valid = 1'b1;
    mul_in   = m;
    add_in   = a;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clear    = 1'b0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (mac_sum !== 16'd0) begin errors++; $display("FAIL reset_mac_sum got=%0d exp=0", mac_sum); end
    checks++; if (add_chk !== 4'd0 || sat_flag !== 1'b0 || smp_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_chk_sat_cnt got=%h/%b/%0d exp=0/0/0", add_chk, sat_flag, smp_cnt);
    end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic_frame();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(8'h0F, 4'h3);
    checks++; if (out_valid !== 1'b0 || smp_cnt !== 4'd3 || mac_sum !== 16'd45) begin
      errors++; $display("FAIL basic_partial got=v%b c%0d m%0d exp=v0 c3 m45", out_valid, smp_cnt, mac_sum);
    end
    send(8'h0F, 4'h3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    checks++; if (mac_sum !== 16'd60) begin errors++; $display("FAIL basic_mac_sum got=%0d exp=60", mac_sum); end
    checks++; if (add_chk !== 4'h0 || sat_flag !== 1'b0) begin
      errors++; $display("FAIL basic_chk_sat got=%h/%b exp=0/0", add_chk, sat_flag);
    end
    step();
    checks++; if (out_valid !== 1'b0 || smp_cnt !== 4'd0) begin
      errors++; $display("FAIL basic_unload got=v%b c%0d exp=v0 c0", out_valid, smp_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'hFF, 4'h1);
    checks++; if (mac_sum9 !== 9'd511 || sat_flag9 !== 1'b1) begin
      errors++; $display("FAIL sat_clamp got=%0d/%b exp=511/1", mac_sum9, sat_flag9);
    end
    checks++; if (mac_sum !== 16'd1020 || sat_flag !== 1'b0) begin
      errors++; $display("FAIL sat_wide_nosat got=%0d/%b exp=1020/0", mac_sum, sat_flag);
    end
    send(8'h01, 4'h2);
    checks++; if (sat_flag9 !== 1'b0 || mac_sum9 !== 9'd1) begin
      errors++; $display("FAIL sat_new_frame got=%0d/%b exp=1/0", mac_sum9, sat_flag9);
    end
    for (int i = 0; i < 3; i++) send(8'h01, 4'h2);
    checks++; if (mac_sum9 !== 9'd4 || sat_flag9 !== 1'b0 || out_valid9 !== 1'b1) begin
      errors++; $display("FAIL sat_next_frame got=%0d/%b/v%b exp=4/0/v1", mac_sum9, sat_flag9, out_valid9);
    end
    step();
  endtask

  task automatic test_hold_backpressure();
    do_reset();
    out_ready = 1'b0;
    send(8'd2, 4'd1); send(8'd2, 4'd2); send(8'd2, 4'd3); send(8'd2, 4'd4);
    in_valid = 1'b1; mul_in = 8'd99; add_in = 4'd5;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || mac_sum !== 16'd8 || add_chk !== 4'd4 || smp_cnt !== 4'd4) begin
        errors++; $display("FAIL hold_stable cyc=%0d got=v%b m%0d k%0d c%0d exp=v1 m8 k4 c4",
                           i, out_valid, mac_sum, add_chk, smp_cnt);
      end
    end
    out_ready = 1'b1; mul_in = 8'd7; add_in = 4'd6;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || smp_cnt !== 4'd1 || mac_sum !== 16'd7 || add_chk !== 4'd6) begin
      errors++; $display("FAIL hold_unload_restart got=v%b c%0d m%0d k%0d exp=v0 c1 m7 k6",
                         out_valid, smp_cnt, mac_sum, add_chk);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_sum;
    do_reset();
    out_ready = 1'b1;
    exp_sum = '0;
    in_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      mul_in = 8'(k);
      add_in = 4'(k - 1);
      exp_sum = ((k - 1) % 4 == 0) ? 16'(k) : exp_sum + 16'(k);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, in_ready); end
      step();
      checks++; if (out_valid !== (k % 4 == 0) || mac_sum !== exp_sum) begin
        errors++; $display("FAIL b2b_out k=%0d got=v%b m%0d exp=v%0d m%0d", k, out_valid, mac_sum, (k % 4 == 0), exp_sum);
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_clear();
    do_reset();
    out_ready = 1'b1;
    send(8'd10, 4'd1); send(8'd20, 4'd2);
    clear = 1'b1; in_valid = 1'b1; mul_in = 8'd50; add_in = 4'd7;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready got=%b exp=0", in_ready); end
    step();
    clear = 1'b0; in_valid = 1'b0;
    checks++; if (smp_cnt !== 4'd0 || mac_sum !== 16'd0 || add_chk !== 4'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL clear_abort got=c%0d m%0d k%0d v%b exp=c0 m0 k0 v0", smp_cnt, mac_sum, add_chk, out_valid);
    end
    for (int i = 0; i < 4; i++) send(8'd1, 4'd0);
    checks++; if (mac_sum !== 16'd4 || out_valid !== 1'b1) begin
      errors++; $display("FAIL clear_refill got=m%0d v%b exp=m4 v1", mac_sum, out_valid);
    end
    clear = 1'b1; out_ready = 1'b0;
    step();
    clear = 1'b0;
    checks++; if (out_valid !== 1'b0 || mac_sum !== 16'd0) begin
      errors++; $display("FAIL clear_hold got=v%b m%0d exp=v0 m0", out_valid, mac_sum);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    out_ready = 1'b1;
    send(8'd5, 4'd1); send(8'd5, 4'd2);
    rst = 1'b1; in_valid = 1'b1; mul_in = 8'd9; add_in = 4'd9;
    step();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || mac_sum !== 16'd0 || add_chk !== 4'd0 ||
                  sat_flag !== 1'b0 || smp_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_mid got=r%b v%b m%0d k%0d s%b c%0d exp=all zero",
                         in_ready, out_valid, mac_sum, add_chk, sat_flag, smp_cnt);
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) send(8'd3, 4'd2);
    checks++; if (mac_sum !== 16'd12 || add_chk !== 4'd0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_frame got=m%0d k%0d v%b exp=m12 k0 v1", mac_sum, add_chk, out_valid);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_saturation();
    test_hold_backpressure();
    test_back_to_back();
    test_clear();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
